// File: rtl/axi_rt_event_irq.sv
// axi_rt_event_irq: rising-edge event capture with sticky status, saturating counters and a
// maskable interrupt. Optional first-event timestamp logic is enabled by AXI_RT_EVENT_IRQ_TS_EN.
`default_nettype none

// +-----------------------------------------------------------------------------------------+
// | Module   : axi_rt_event_irq                                                             |
// | Purpose  : RT unit status -> sticky events, counters, interrupt (TS: AXI_RT_EVENT_IRQ_TS_EN) |
// | Revision : 1.0                                                                          |
// +-----------------------------------------------------------------------------------------+
module axi_rt_event_irq #(
    parameter int NumAddrRegions = 2,
    parameter int CntWidth       = 16,
    parameter int TsWidth        = 32,
    localparam int NumEvents     = 3 + 2 * NumAddrRegions,
    localparam int IdxWidth      = $clog2(NumEvents)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            w_decode_error_i,
    input  logic                            r_decode_error_i,
    input  logic                            isolate_i,
    input  logic [NumAddrRegions-1:0]       w_exhausted_i,
    input  logic [NumAddrRegions-1:0]       r_exhausted_i,
    input  logic [NumEvents-1:0]            mask_i,
    input  logic [NumEvents-1:0]            status_clr_i,
    input  logic [NumEvents-1:0]            cnt_clr_i,
    output logic [NumEvents-1:0]            status_o,
    output logic [NumEvents*CntWidth-1:0]   cnt_o,
    output logic                            irq_o,
    output logic [TsWidth-1:0]              first_ts_o,
    output logic [IdxWidth-1:0]             first_idx_o
);

    logic [NumEvents-1:0] lv;
    logic [NumEvents-1:0] prev_q;
    logic [NumEvents-1:0] ev;
    logic [NumEvents-1:0] status_q;
    logic [NumEvents-1:0] status_d;
    logic                 irq_q;

    assign lv       = {r_exhausted_i, w_exhausted_i, isolate_i, r_decode_error_i, w_decode_error_i};
    assign ev       = lv & ~prev_q;
    // A new event on the same edge as its clear keeps the bit set.
    assign status_d = ev | (status_q & ~status_clr_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q   <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            prev_q   <= lv;
            status_q <= status_d;
            irq_q    <= |(status_d & mask_i);
        end
    end

    assign status_o = status_q;
    assign irq_o    = irq_q;

    for (genvar k = 0; k < NumEvents; k++) begin : g_cnt
        logic [CntWidth-1:0] cnt_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else if (cnt_clr_i[k]) begin
                cnt_q <= ev[k] ? {{(CntWidth-1){1'b0}}, 1'b1} : '0;
            end else if (ev[k] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign cnt_o[k*CntWidth +: CntWidth] = cnt_q;
    end

`ifdef AXI_RT_EVENT_IRQ_TS_EN
    logic [TsWidth-1:0]  ts_q;
    logic [TsWidth-1:0]  first_ts_q;
    logic [IdxWidth-1:0] first_idx_q;
    logic [IdxWidth-1:0] first_idx_d;

    always_comb begin
        first_idx_d = '0;
        for (int k = NumEvents - 1; k >= 0; k--) begin
            if (ev[k]) begin
                first_idx_d = IdxWidth'(k);
            end
        end
    end

    // Capture only the first batch after status has been fully cleared.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts_q        <= '0;
            first_ts_q  <= '0;
            first_idx_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
            if ((status_q == '0) && (|ev)) begin
                first_ts_q  <= ts_q;
                first_idx_q <= first_idx_d;
            end
        end
    end

    assign first_ts_o  = first_ts_q;
    assign first_idx_o = first_idx_q;
`else
    assign first_ts_o  = '0;
    assign first_idx_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_rt_event_irq.sv
// Self-checking bench for axi_rt_event_irq: vector table, corner sequences, random vs. model.
`default_nettype none

module tb_axi_rt_event_irq;

    localparam int NR  = 2;
    localparam int CW  = 6;
    localparam int TW  = 32;
    localparam int NE  = 3 + 2 * NR;
    localparam int IW  = $clog2(NE);
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NE-1:0]     lv;
    logic [NE-1:0]     mask;
    logic [NE-1:0]     sclr;
    logic [NE-1:0]     cclr;
    logic [NE-1:0]     status;
    logic [NE*CW-1:0]  cnt;
    logic              irq;
    logic [TW-1:0]     first_ts;
    logic [IW-1:0]     first_idx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_rt_event_irq #(
        .NumAddrRegions (NR),
        .CntWidth       (CW),
        .TsWidth        (TW)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .w_decode_error_i (lv[0]),
        .r_decode_error_i (lv[1]),
        .isolate_i        (lv[2]),
        .w_exhausted_i    (lv[3 +: NR]),
        .r_exhausted_i    (lv[3+NR +: NR]),
        .mask_i           (mask),
        .status_clr_i     (sclr),
        .cnt_clr_i        (cclr),
        .status_o         (status),
        .cnt_o            (cnt),
        .irq_o            (irq),
        .first_ts_o       (first_ts),
        .first_idx_o      (first_idx)
    );

    // Reference model: per-event arrays updated once per clock edge.
    bit            prev_m [NE];
    bit            st_m   [NE];
    int            cnt_m  [NE];
    bit            irq_m;
    logic [TW-1:0] ts_m;
    logic [TW-1:0] fts_m;
    int            fidx_m;

    task automatic model_reset();
        for (int k = 0; k < NE; k++) begin
            prev_m[k] = 0; st_m[k] = 0; cnt_m[k] = 0;
        end
        irq_m = 0; ts_m = '0; fts_m = '0; fidx_m = 0;
    endtask

    task automatic model_edge();
        bit ev [NE];
        bit any_old = 0;
        bit any_ev  = 0;
        int low     = -1;
        for (int k = 0; k < NE; k++) begin
            ev[k] = lv[k] && !prev_m[k];
            if (st_m[k]) any_old = 1;
            if (ev[k]) begin
                any_ev = 1;
                if (low < 0) low = k;
            end
        end
        if (!any_old && any_ev) begin
            fts_m  = ts_m;
            fidx_m = low;
        end
        irq_m = 0;
        for (int k = 0; k < NE; k++) begin
            if (ev[k])        st_m[k] = 1;
            else if (sclr[k]) st_m[k] = 0;
            if (cclr[k])      cnt_m[k] = ev[k] ? 1 : 0;
            else if (ev[k])   cnt_m[k] = (cnt_m[k] < CMAX) ? cnt_m[k] + 1 : CMAX;
            if (st_m[k] && mask[k]) irq_m = 1;
            prev_m[k] = lv[k];
        end
        ts_m = ts_m + 1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [NE-1:0] st_v;
        for (int k = 0; k < NE; k++) begin
            st_v[k] = st_m[k];
            check($sformatf("model_cnt%0d", k), 64'(cnt[k*CW +: CW]), 64'(cnt_m[k]));
        end
        check("model_status", 64'(status), 64'(st_v));
        check("model_irq", 64'(irq), 64'(irq_m));
`ifdef AXI_RT_EVENT_IRQ_TS_EN
        check("model_first_ts", 64'(first_ts), 64'(fts_m));
        check("model_first_idx", 64'(first_idx), 64'(fidx_m));
`else
        check("tied_first_ts", 64'(first_ts), 64'd0);
        check("tied_first_idx", 64'(first_idx), 64'd0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    // Called 1 time unit after a posedge; asserts reset between edges.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_status", 64'(status), 64'd0);
        check("rst_cnt", 64'(cnt), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_first_ts", 64'(first_ts), 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [NE-1:0] lv;
        logic [NE-1:0] mask;
        logic [NE-1:0] sclr;
        logic [NE-1:0] exp_status;
        logic          exp_irq;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{7'b0000001, 7'b0000000, 7'b0000000, 7'b0000001, 1'b0};
        tbl[1] = '{7'b0000001, 7'b0000001, 7'b0000000, 7'b0000001, 1'b1};
        tbl[2] = '{7'b0000000, 7'b0000001, 7'b0000001, 7'b0000000, 1'b0};
        tbl[3] = '{7'b0000100, 7'b0000100, 7'b0000000, 7'b0000100, 1'b1};
        tbl[4] = '{7'b0000100, 7'b0000100, 7'b0000100, 7'b0000000, 1'b0};
        tbl[5] = '{7'b0001000, 7'b0000000, 7'b0001000, 7'b0001000, 1'b0};
        tbl[6] = '{7'b0000000, 7'b0001000, 7'b0000000, 7'b0001000, 1'b1};
        tbl[7] = '{7'b0000000, 7'b0000000, 7'b0000000, 7'b0001000, 1'b0};
        tbl[8] = '{7'b1100000, 7'b1000000, 7'b0000000, 7'b1101000, 1'b1};
        tbl[9] = '{7'b0000000, 7'b1111111, 7'b1101000, 7'b0000000, 1'b0};

        rst = 1'b1; lv = '0; mask = '0; sclr = '0; cclr = '0;
        model_reset();
        #2;
        check("por_status", 64'(status), 64'd0);
        check("por_irq", 64'(irq), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors from a clean reset.
        foreach (tbl[i]) begin
            lv = tbl[i].lv; mask = tbl[i].mask; sclr = tbl[i].sclr;
            step();
            check($sformatf("tbl%0d_status", i), 64'(status), 64'(tbl[i].exp_status));
            check($sformatf("tbl%0d_irq", i), 64'(irq), 64'(tbl[i].exp_irq));
        end
        sclr = '0; mask = '0; lv = '0;

        // Long level pulse counts once; masked-off event gives no irq.
        do_reset();
        lv[0] = 1'b1;
        repeat (5) step();
        lv[0] = 1'b0;
        step();
        check("pulse_status0", 64'(status[0]), 64'd1);
        check("pulse_cnt0", 64'(cnt[0 +: CW]), 64'd1);
        check("pulse_irq", 64'(irq), 64'd0);

        // Counter saturation, then clear coincident with an edge.
        for (int i = 0; i < 70; i++) begin
            lv[6] = 1'b1; step();
            lv[6] = 1'b0; step();
        end
        check("sat_cnt6", 64'(cnt[6*CW +: CW]), 64'(CMAX));
        lv[6] = 1'b1; cclr[6] = 1'b1;
        step();
        check("clr_edge_cnt6", 64'(cnt[6*CW +: CW]), 64'd1);
        cclr = '0; lv = '0;
        step();

        // Asynchronous reset mid-operation with inputs held high.
        do_reset();
        lv = 7'h1F;
        step();
        check("pre_rst_status", 64'(status), 64'h1F);
        step();
        do_reset();
        step();
        check("post_rst_status", 64'(status), 64'h1F);
        check("post_rst_cnt0", 64'(cnt[0 +: CW]), 64'd1);
        lv = '0;

`ifdef AXI_RT_EVENT_IRQ_TS_EN
        // First-event timestamp capture and hold.
        do_reset();
        repeat (100) step();
        lv[4] = 1'b1; lv[1] = 1'b1;
        step();
        check("ts100_first_ts", 64'(first_ts), 64'd100);
        check("ts100_first_idx", 64'(first_idx), 64'd1);
        repeat (99) step();
        lv[0] = 1'b1;
        step();
        check("ts200_hold_ts", 64'(first_ts), 64'd100);
        check("ts200_hold_idx", 64'(first_idx), 64'd1);
        sclr = '1; lv = '0;
        step();
        sclr = '0;
        repeat (98) step();
        lv[2] = 1'b1;
        step();
        check("ts300_first_ts", 64'(first_ts), 64'd300);
        check("ts300_first_idx", 64'(first_idx), 64'd2);
        lv = '0;
`endif

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            lv   = NE'($urandom);
            mask = NE'($urandom);
            sclr = ($urandom_range(0, 3) == 0) ? NE'($urandom) : '0;
            cclr = ($urandom_range(0, 7) == 0) ? NE'($urandom) : '0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
